// File: rtl/targ_uart_pkg.sv
// ---------------------------------------------------------------------------
// targ_uart_pkg
// Shared definitions for the target-side UART blocks.
//   - rx_state_t : receiver frame-state encoding
//   - OVERSAMPLE : oversample ticks per bit (fixed at 8)
//   - MID_SAMPLE : oversample count at which the start bit is re-checked
//   - parity8()  : XOR reduction of one character, used for even parity
// ---------------------------------------------------------------------------
package targ_uart_pkg;

    localparam int OVERSAMPLE = 8;
    localparam int MID_SAMPLE = 3;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_START      = 3'd1,
        ST_DATA       = 3'd2,
        ST_PARITY     = 3'd3,
        ST_STOP1      = 3'd4,
        ST_STOP2      = 3'd5,
        ST_BREAK_WAIT = 3'd6
    } rx_state_t;

    function automatic logic parity8(input logic [7:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/targ_uart_baud_tick.sv
// ---------------------------------------------------------------------------
// targ_uart_baud_tick
// Fractional baud generator. A free-running accumulator adds the increment
// every clock; the carry out of the low bits is the oversample tick.
// Ports:
//   clk      in   system clock
//   reset_n  in   synchronous active-low reset
//   inc      in   BaudGeneratorAccWidth-bit increment (Baud*8*2^W/Fclk)
//   tick     out  one-clock oversample tick
// ---------------------------------------------------------------------------
module targ_uart_baud_tick #(
    parameter int BaudGeneratorAccWidth = 16
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic [BaudGeneratorAccWidth-1:0] inc,
    output logic                             tick
);

    logic [BaudGeneratorAccWidth:0] acc;

    // The carry bit is dropped before each add so it only lives for one
    // clock, which makes it directly usable as the tick.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            acc <= '0;
        end else begin
            acc <= {1'b0, acc[BaudGeneratorAccWidth-1:0]} + {1'b0, inc};
        end
    end

    assign tick = acc[BaudGeneratorAccWidth];

endmodule

// File: rtl/targ_async_receiver.sv
// ---------------------------------------------------------------------------
// targ_async_receiver
// UART receiver for the target serial link: 8 data bits LSB first, optional
// even parity, one or two stop bits, 8x oversampling with a 3-sample
// majority filter. Results are presented with a one-clock strobe.
// Ports:
//   clk                   in   system clock (UART_CLK domain)
//   reset_n               in   synchronous active-low reset
//   RxD                   in   asynchronous serial line, idles high
//   parity_even           in   1 = parity bit follows bit 7
//   two_stopbits          in   1 = two stop bits are checked
//   RxD_BaudGeneratorInc  in   baud accumulator increment
//   RxD_data              out  last received character
//   RxD_data_ready        out  one-clock strobe, data and flags valid
//   RxD_parity_error      out  parity error of the last character
//   RxD_framing_error     out  framing error of the last character
//   RxD_idle              out  high while the receiver is idle
// ---------------------------------------------------------------------------
module targ_async_receiver
    import targ_uart_pkg::*;
#(
    parameter int BaudGeneratorAccWidth = 16
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             RxD,
    input  logic                             parity_even,
    input  logic                             two_stopbits,
    input  logic [BaudGeneratorAccWidth-1:0] RxD_BaudGeneratorInc,
    output logic [7:0]                       RxD_data,
    output logic                             RxD_data_ready,
    output logic                             RxD_parity_error,
    output logic                             RxD_framing_error,
    output logic                             RxD_idle
);

    logic       tick;

    logic       sync_meta;
    logic       sync_out;
    logic [2:0] history;
    logic       filtered;

    rx_state_t  state;
    logic [2:0] os_cnt;
    logic [2:0] bit_idx;
    logic [7:0] shift_reg;
    logic       cfg_parity;
    logic       cfg_two_stop;
    logic       perr_acc;
    logic       ferr_acc;
    logic       frame_done;
    logic       bit_end;
    logic       stop_ferr;

    targ_uart_baud_tick #(
        .BaudGeneratorAccWidth(BaudGeneratorAccWidth)
    ) u_baud_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (RxD_BaudGeneratorInc),
        .tick    (tick)
    );

    // Two-flop synchronizer, then a 3-deep history loaded only on ticks so
    // the majority vote spans three oversample periods. Everything resets
    // to 1 so the idle line never looks like a start bit after reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_meta <= 1'b1;
            sync_out  <= 1'b1;
            history   <= 3'b111;
        end else begin
            sync_meta <= RxD;
            sync_out  <= sync_meta;
            if (tick) begin
                history <= {history[1:0], sync_out};
            end
        end
    end

    assign filtered = (history[0] & history[1]) |
                      (history[1] & history[2]) |
                      (history[0] & history[2]);

    // Last oversample tick of a bit period: the bit is sampled here.
    assign bit_end = (os_cnt == 3'(OVERSAMPLE - 1));

    // Framing error including the stop bit being sampled on this tick.
    assign stop_ferr = ferr_acc | ~filtered;

    // Frame state machine. All state changes happen on ticks; the result
    // is published one clock after the final stop sample via frame_done,
    // so the strobe, data and flags always change on the same edge.
    // RxD_idle is kept in step with every transition into or out of IDLE.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state             <= ST_IDLE;
            os_cnt            <= 3'd0;
            bit_idx           <= 3'd0;
            shift_reg         <= 8'h00;
            cfg_parity        <= 1'b0;
            cfg_two_stop      <= 1'b0;
            perr_acc          <= 1'b0;
            ferr_acc          <= 1'b0;
            frame_done        <= 1'b0;
            RxD_data          <= 8'h00;
            RxD_data_ready    <= 1'b0;
            RxD_parity_error  <= 1'b0;
            RxD_framing_error <= 1'b0;
            RxD_idle          <= 1'b1;
        end else begin
            RxD_data_ready <= frame_done;
            frame_done     <= 1'b0;
            if (frame_done) begin
                RxD_data          <= shift_reg;
                RxD_parity_error  <= perr_acc;
                RxD_framing_error <= ferr_acc;
            end

            if (tick) begin
                case (state)
                    ST_IDLE: begin
                        if (!filtered) begin
                            state        <= ST_START;
                            RxD_idle     <= 1'b0;
                            os_cnt       <= 3'd0;
                            cfg_parity   <= parity_even;
                            cfg_two_stop <= two_stopbits;
                            perr_acc     <= 1'b0;
                            ferr_acc     <= 1'b0;
                        end
                    end

                    // Re-check the start bit near its middle to reject
                    // short glitches on the idle line.
                    ST_START: begin
                        if (os_cnt == 3'(MID_SAMPLE)) begin
                            os_cnt <= 3'd0;
                            if (!filtered) begin
                                state   <= ST_DATA;
                                bit_idx <= 3'd0;
                            end else begin
                                state    <= ST_IDLE;
                                RxD_idle <= 1'b1;
                            end
                        end else begin
                            os_cnt <= os_cnt + 3'd1;
                        end
                    end

                    ST_DATA: begin
                        if (bit_end) begin
                            os_cnt    <= 3'd0;
                            shift_reg <= {filtered, shift_reg[7:1]};
                            bit_idx   <= bit_idx + 3'd1;
                            if (bit_idx == 3'd7) begin
                                state <= cfg_parity ? ST_PARITY : ST_STOP1;
                            end
                        end else begin
                            os_cnt <= os_cnt + 3'd1;
                        end
                    end

                    ST_PARITY: begin
                        if (bit_end) begin
                            os_cnt   <= 3'd0;
                            perr_acc <= filtered ^ parity8(shift_reg);
                            state    <= ST_STOP1;
                        end else begin
                            os_cnt <= os_cnt + 3'd1;
                        end
                    end

                    ST_STOP1: begin
                        if (bit_end) begin
                            os_cnt   <= 3'd0;
                            ferr_acc <= stop_ferr;
                            if (cfg_two_stop) begin
                                state <= ST_STOP2;
                            end else begin
                                frame_done <= 1'b1;
                                if (stop_ferr) begin
                                    state <= ST_BREAK_WAIT;
                                end else begin
                                    state    <= ST_IDLE;
                                    RxD_idle <= 1'b1;
                                end
                            end
                        end else begin
                            os_cnt <= os_cnt + 3'd1;
                        end
                    end

                    ST_STOP2: begin
                        if (bit_end) begin
                            os_cnt     <= 3'd0;
                            ferr_acc   <= stop_ferr;
                            frame_done <= 1'b1;
                            if (stop_ferr) begin
                                state <= ST_BREAK_WAIT;
                            end else begin
                                state    <= ST_IDLE;
                                RxD_idle <= 1'b1;
                            end
                        end else begin
                            os_cnt <= os_cnt + 3'd1;
                        end
                    end

                    // A held-low line would otherwise restart a frame every
                    // character time; wait for the line to recover first.
                    ST_BREAK_WAIT: begin
                        if (filtered) begin
                            state    <= ST_IDLE;
                            RxD_idle <= 1'b1;
                        end
                    end

                    default: begin
                        state    <= ST_IDLE;
                        RxD_idle <= 1'b1;
                        os_cnt   <= 3'd0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_targ_async_receiver.sv
// ---------------------------------------------------------------------------
// tb_targ_async_receiver
// Self-checking bench for targ_async_receiver. Frames are driven as ideal
// serial waveforms; the expected character and error flags are derived from
// what was put on the line (character, parity bit, stop bit levels).
// ---------------------------------------------------------------------------
module tb_targ_async_receiver;

    typedef struct packed {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } rx_rec_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        RxD;
    logic        parity_even;
    logic        two_stopbits;
    logic [15:0] RxD_BaudGeneratorInc;
    logic [7:0]  RxD_data;
    logic        RxD_data_ready;
    logic        RxD_parity_error;
    logic        RxD_framing_error;
    logic        RxD_idle;

    int          n_compared   = 0;
    int          n_mismatched = 0;
    int          strobe_count = 0;
    int          exp_total    = 0;
    int          bit_clks     = 347;
    rx_rec_t     got_q[$];
    rx_rec_t     exp_q[$];
    int          inc_table[3] = '{3020, 6040, 12080};
    logic [7:0]  rnd_char;
    logic        rnd_par;
    logic        rnd_stop1;
    logic        rnd_stop2;

    targ_async_receiver dut (
        .clk                  (clk),
        .reset_n              (reset_n),
        .RxD                  (RxD),
        .parity_even          (parity_even),
        .two_stopbits         (two_stopbits),
        .RxD_BaudGeneratorInc (RxD_BaudGeneratorInc),
        .RxD_data             (RxD_data),
        .RxD_data_ready       (RxD_data_ready),
        .RxD_parity_error     (RxD_parity_error),
        .RxD_framing_error    (RxD_framing_error),
        .RxD_idle             (RxD_idle)
    );

    always #5 clk = ~clk;

    // Capture every strobe on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (RxD_data_ready === 1'b1) begin
            got_q.push_back(rx_rec_t'{data: RxD_data,
                                      perr: RxD_parity_error,
                                      ferr: RxD_framing_error});
            strobe_count++;
        end
    end

    // Hard stop in case the sequence below ever stalls.
    initial begin
        #1500000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_value(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_compared++;
        assert (observed === expected) else begin
            n_mismatched++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic set_baud(input int inc);
        RxD_BaudGeneratorInc = 16'(inc);
        bit_clks = (524288 + inc / 2) / inc;
    endtask

    task automatic hold_line(input logic level, input int clocks);
        RxD = level;
        repeat (clocks) @(negedge clk);
    endtask

    task automatic push_expected(input logic [7:0] data, input logic perr, input logic ferr);
        exp_q.push_back(rx_rec_t'{data: data, perr: perr, ferr: ferr});
        exp_total++;
    endtask

    // One complete frame using the current parity/stop configuration; the
    // expected result follows directly from the levels driven on the line.
    task automatic apply_stimulus(input logic [7:0] ch, input logic par_bit,
                                  input logic stop1, input logic stop2);
        logic exp_perr;
        logic exp_ferr;
        exp_perr = parity_even ? (par_bit ^ (^ch)) : 1'b0;
        exp_ferr = !stop1 || (two_stopbits && !stop2);
        push_expected(ch, exp_perr, exp_ferr);
        hold_line(1'b0, bit_clks);
        for (int i = 0; i < 8; i++) begin
            hold_line(ch[i], bit_clks);
        end
        if (parity_even) begin
            hold_line(par_bit, bit_clks);
        end
        hold_line(stop1, bit_clks);
        if (two_stopbits) begin
            hold_line(stop2, bit_clks);
        end
        RxD = 1'b1;
    endtask

    // Wait (bounded) for the expected strobes, then compare in order.
    task automatic check_output(input string tag);
        int      budget;
        rx_rec_t e;
        rx_rec_t g;
        budget = 4 * bit_clks;
        while (got_q.size() < exp_q.size() && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check_value({tag, " strobes"}, 32'(got_q.size()), 32'(exp_q.size()));
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            check_value({tag, " data"}, 32'(g.data), 32'(e.data));
            check_value({tag, " perr"}, 32'(g.perr), 32'(e.perr));
            check_value({tag, " ferr"}, 32'(g.ferr), 32'(e.ferr));
        end
        exp_q.delete();
        got_q.delete();
    endtask

    initial begin
        RxD          = 1'b1;
        reset_n      = 1'b0;
        parity_even  = 1'b0;
        two_stopbits = 1'b0;
        set_baud(1510);
        repeat (4) @(negedge clk);

        // Reset values
        check_value("reset data",  32'(RxD_data),          32'h00);
        check_value("reset ready", 32'(RxD_data_ready),    32'd0);
        check_value("reset perr",  32'(RxD_parity_error),  32'd0);
        check_value("reset ferr",  32'(RxD_framing_error), 32'd0);
        check_value("reset idle",  32'(RxD_idle),          32'd1);
        reset_n = 1'b1;
        hold_line(1'b1, 2 * bit_clks);

        // 0x55 as 8N1 at 115200 baud from 40 MHz
        apply_stimulus(8'h55, 1'b0, 1'b1, 1'b1);
        check_output("8n1_55");
        hold_line(1'b1, bit_clks);
        check_value("8n1_55 idle", 32'(RxD_idle), 32'd1);

        // Faster baud for the remaining directed tests
        set_baud(6040);
        hold_line(1'b1, 2 * bit_clks);

        // Even parity, correct and incorrect parity bit
        parity_even = 1'b1;
        apply_stimulus(8'hA5, 1'b0, 1'b1, 1'b1);
        hold_line(1'b1, bit_clks);
        apply_stimulus(8'hA5, 1'b1, 1'b1, 1'b1);
        check_output("parity_a5");
        parity_even = 1'b0;
        hold_line(1'b1, bit_clks);

        // Two-oversample-period glitch must not produce a character
        hold_line(1'b0, bit_clks / 4);
        hold_line(1'b1, 2 * bit_clks);
        check_output("glitch");
        check_value("glitch idle", 32'(RxD_idle), 32'd1);

        // Break: one 0x00 framing error, then held off until line recovers
        push_expected(8'h00, 1'b0, 1'b1);
        hold_line(1'b0, 20 * bit_clks);
        check_output("break");
        check_value("break held", 32'(RxD_idle), 32'd0);
        hold_line(1'b1, bit_clks);
        check_value("break released", 32'(RxD_idle), 32'd1);
        apply_stimulus(8'h3C, 1'b0, 1'b1, 1'b1);
        check_output("after_break");
        hold_line(1'b1, bit_clks);

        // Second stop bit low
        two_stopbits = 1'b1;
        apply_stimulus(8'h81, 1'b0, 1'b1, 1'b0);
        check_output("stop2_81");
        hold_line(1'b1, 2 * bit_clks);
        two_stopbits = 1'b0;

        // Back-to-back frames with no idle gap
        apply_stimulus(8'h01, 1'b0, 1'b1, 1'b1);
        apply_stimulus(8'h02, 1'b0, 1'b1, 1'b1);
        apply_stimulus(8'h03, 1'b0, 1'b1, 1'b1);
        check_output("b2b");
        hold_line(1'b1, bit_clks);

        // Reset during bit 4 abandons the frame
        hold_line(1'b0, bit_clks);
        hold_line(1'b0, bit_clks);
        hold_line(1'b1, bit_clks);
        hold_line(1'b0, bit_clks);
        hold_line(1'b1, bit_clks);
        hold_line(1'b1, bit_clks / 2);
        reset_n = 1'b0;
        RxD     = 1'b1;
        repeat (3) @(negedge clk);
        check_value("midreset data", 32'(RxD_data),          32'h00);
        check_value("midreset idle", 32'(RxD_idle),          32'd1);
        check_value("midreset perr", 32'(RxD_parity_error),  32'd0);
        check_value("midreset ferr", 32'(RxD_framing_error), 32'd0);
        reset_n = 1'b1;
        hold_line(1'b1, 2 * bit_clks);
        check_output("midreset");
        apply_stimulus(8'hC3, 1'b0, 1'b1, 1'b1);
        check_output("after_reset");
        hold_line(1'b1, bit_clks);

        // Randomized frames across baud rates and configurations
        for (int n = 0; n < 6; n++) begin
            set_baud(inc_table[$urandom_range(0, 2)]);
            parity_even  = 1'($urandom_range(0, 1));
            two_stopbits = 1'($urandom_range(0, 1));
            rnd_char     = 8'($urandom_range(0, 255));
            rnd_par      = 1'($urandom_range(0, 1));
            rnd_stop1    = ($urandom_range(0, 3) != 0);
            rnd_stop2    = ($urandom_range(0, 3) != 0);
            hold_line(1'b1, 2 * bit_clks);
            apply_stimulus(rnd_char, rnd_par, rnd_stop1, rnd_stop2);
            check_output($sformatf("random%0d", n));
            hold_line(1'b1, bit_clks);
        end

        check_value("total strobes", 32'(strobe_count), 32'(exp_total));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/targ_async_receiver.md
Name: targ_async_receiver

Overview:
- UART receive end of the target serial link, the counterpart to the target-side async transmitter.
- Recovers 8-bit characters from the asynchronous RxD line with 8x oversampling from a programmable fractional baud accumulator.
- Supports optional even parity and one or two stop bits; flags parity and framing errors.
- Feeds the target serial FIFO/register logic through a one-cycle data_ready strobe.

Parameters:
- BaudGeneratorAccWidth, 16, width of the baud increment input; the accumulator is this width plus 1.
- OVERSAMPLE, 8, oversample ticks per bit. Fixed; the RTL need not support other values.
- MID_SAMPLE, 3, oversample count at which the start bit is re-checked (mid-bit).

Ports:
- clk  in  1  system clock (UART_CLK domain).
- reset_n  in  1  synchronous, active-low reset.
- RxD  in  1  asynchronous serial input; idles high.
- parity_even  in  1  1 = a parity bit follows bit 7.
- two_stopbits  in  1  1 = two stop bits are checked.
- RxD_BaudGeneratorInc  in  16  increment, equal to round(Baud*8*2^16/Fclk).
- RxD_data  out  8  last received character; LSB is received first.
- RxD_data_ready  out  1  one-clk strobe when RxD_data and the error flags are valid.
- RxD_parity_error  out  1  valid with the strobe; held until the next strobe.
- RxD_framing_error  out  1  valid with the strobe; held until the next strobe.
- RxD_idle  out  1  high when the state is IDLE.

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - State goes to IDLE; accumulator and oversample counter go to 0.
  - Synchronizer and filter registers go to 1.
  - RxD_data=0x00, RxD_data_ready=0, both error flags=0, RxD_idle=1.
  - Reset mid-frame abandons the frame with no strobe.
- Baud tick:
  - Each clk: acc <= acc[15:0] + Inc.
  - tick = acc[16]; the accumulator is free-running, not gated by busy.
  - Changes to Inc take effect on the next clk.
- Input conditioning:
  - RxD passes through 2 flip-flops (the synchronizer).
  - On each tick, the synced bit shifts into a 3-bit history; the filtered bit is the majority of the history.
- Config capture: parity_even and two_stopbits are registered on leaving IDLE and are constant for the frame.
- States: IDLE, START, DATA (bit index 0..7), PARITY, STOP1, STOP2, BREAK_WAIT. All transitions occur only on tick edges.
- IDLE: on a tick with filtered=0, go to START and set os_cnt=0.
- START: os_cnt increments each tick. At os_cnt==MID_SAMPLE:
  - filtered=0: go to DATA with bit 0 and os_cnt=0.
  - filtered=1: go to IDLE (false start, no strobe).
- DATA/PARITY/STOP1/STOP2: on the tick where os_cnt==7, sample the filtered bit, advance, and set os_cnt=0; otherwise os_cnt increments.
- Data sampling: DATA shifts the sampled bit into a shift register, LSB first.
- After bit 7: go to PARITY if parity_even, else STOP1.
- PARITY: perr = sample XOR (XOR of the 8 data bits); the expected value is the XOR of the data bits.
- STOP1: ferr |= ~sample; go to STOP2 if two_stopbits, else end of frame.
- STOP2: ferr |= ~sample; end of frame.
- End of frame (the clk after the final stop sample edge):
  - RxD_data_ready=1 for exactly one clk.
  - RxD_data, RxD_parity_error and RxD_framing_error update on the same edge.
  - Data is delivered even when an error flag is set.
  - Parity error is 0 when parity is disabled.
- Next state after end of frame:
  - No framing error: IDLE.
  - Framing error: BREAK_WAIT, which holds until a tick with filtered=1 and then goes to IDLE. This prevents re-triggering during a continuous break.
- Back-to-back frames: a start edge on the first IDLE tick after a stop bit must be accepted (zero idle gap).
- A tick and a reset on the same edge: reset wins.

Decomposition:
- Shared package targ_uart_pkg holds:
  - the state encoding enum;
  - OVERSAMPLE and MID_SAMPLE;
  - the parity helper function (XOR reduce of 8 bits).
- Sub-module targ_uart_baud_tick holds the accumulator plus tick output. The transmitter may later reuse it.

Test Plan:
- Inc=1510 (40 MHz, 115200 baud); send 0x55 as 8N1. Expect RxD_data=0x55, one strobe, perr=0, ferr=0, and RxD_idle returning to 1.
- parity_even=1; send 0xA5 with parity bit 0. Expect 0xA5 and perr=0. Repeat with parity bit 1: expect 0xA5 and perr=1.
- Low glitch of 2 oversample periods on an idle line. Expect no strobe and return to IDLE.
- Break: line low for 20 bit times. Expect one strobe with 0x00 and ferr=1, state held in BREAK_WAIT until the line goes high, then 0x3C received normally.
- two_stopbits=1; second stop bit driven 0 on 0x81. Expect 0x81 with ferr=1. Back-to-back 0x01,0x02,0x03 with no gap: expect three strobes in order.
- Assert reset_n=0 during bit 4 of a frame. Expect outputs at reset values, no strobe, and the following frame 0xC3 received correctly.
